sobel_rd_port_arbiter: RTL and testbench
========================================

Name: sobel_rd_port_arbiter

Overview:
- Shares one single-port read BRAM (`blk_mem_read` style: `ena`/`addra` in, `douta` out, fixed read latency) between NUM_REQ Sobel patch fetchers.
- Round-robin arbitration with a per-requester lock, so a 3x3 patch fetch (9 reads) issues back-to-back without interleaving.
- Returns data to the owning requester with a per-requester valid strobe.
- Sits between the patch-fetch FSMs and the input BRAM instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 16, BRAM address width.
- DATA_W, 8, pixel width.
- RD_LATENCY, 1, BRAM clocks from registered ena/addra to valid douta (1..3).
- MAX_BURST, 9, max consecutive locked grants before forced release.

Ports:
- clka  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  read request per requester
- req_addr  in  NUM_REQ*ADDR_W  address; slice i = bits [i*ADDR_W +: ADDR_W]
- req_lock  in  NUM_REQ  keep ownership after this beat
- req_ready  out  NUM_REQ  request accepted this cycle (combinational, one-hot or zero)
- rsp_valid  out  NUM_REQ  read data valid for requester i (registered, one-hot or zero)
- rsp_data  out  DATA_W  equals bram_douta; meaningful only when a rsp_valid bit is high
- bram_ena  out  1  BRAM enable (registered)
- bram_addra  out  ADDR_W  BRAM address (registered)
- bram_douta  in  DATA_W  BRAM read data
- owner_id  out  2  current lock owner, 0 when unowned
- stall_cnt  out  16  saturating count of cycles with at least one valid request not accepted

Behaviour:
- Interface: one clock `clka`; `reset` is synchronous and active-high.
- Reset values: req_ready 0, rsp_valid 0, bram_ena 0, bram_addra 0, owner_id 0, stall_cnt 0. Internal state: state=FREE, rr_ptr=0, burst_cnt=0, tag pipe cleared.
- Reset mid-burst: lock, burst_cnt and the tag pipe are cleared; in-flight responses are dropped (no rsp_valid after reset).
- State FREE (no owner):
  - Grant the first requester with req_valid high, searching from rr_ptr upward and wrapping mod NUM_REQ.
  - On a grant i with req_lock[i]=1: go to OWNED(owner=i), burst_cnt=1.
  - Otherwise: stay FREE, rr_ptr=i+1 mod NUM_REQ.
- State OWNED(o):
  - Only o may be granted.
  - If req_valid[o]=0: release that same cycle, go to FREE, rr_ptr=o+1, and run the FREE arbitration in the same cycle (no dead cycle).
  - If req_valid[o]=1: grant o and burst_cnt+1. Release to FREE (rr_ptr=o+1) if req_lock[o]=0, or if burst_cnt reaches MAX_BURST after this grant (forced release; the lock is ignored).
  - A forced-released requester re-arbitrates normally and can win again only after other pending requesters are served.
- Grants: req_ready[i]=1 iff i is granted this cycle. At most one grant per cycle.
- Issue: on a grant, the next edge sets bram_ena=1 and bram_addra=req_addr[i]. With no grant, bram_ena=0 and bram_addra holds its value.
- Return:
  - A tag shift register of depth RD_LATENCY carries {valid, id}.
  - rsp_valid[id] is asserted exactly 1+RD_LATENCY cycles after the req_ready cycle; rsp_data=bram_douta in that cycle.
  - Responses come back in acceptance order, one per cycle at full throughput.
- owner_id updates with the state register.
- stall_cnt: +1 per cycle where req_valid & ~req_ready is nonzero; saturates at 0xFFFF.
- Simultaneous events: a lock drop and a new request from another requester in the same cycle are both handled in that cycle; the new request is eligible next cycle per rr_ptr. No combinational path from req_* to bram_* or rsp_*.

Test Plan:
- Single requester, RD_LATENCY=1: req 0 valid with addr 0x0102 at cycle t. Expect req_ready[0] at t, bram_ena=1 and bram_addra=0x0102 at t+1, rsp_valid[0]=1 at t+2 with rsp_data equal to the model BRAM word.
- Contention, no lock: both valid continuously with distinct addresses. Grants alternate 0,1,0,1 from reset; stall_cnt increments by 1 per cycle.
- Locked patch fetch: req 0 holds lock for 8 beats then drops it on the 9th while req 1 waits. Expect 9 consecutive grants to 0, then a grant to 1 the next cycle; 9 ordered rsp_valid[0] pulses.
- Forced release: req 0 holds lock indefinitely with req 1 pending, MAX_BURST=9. Expect 9 grants to 0, then 1 grant to 1, then 0 regains ownership.
- Owner drops valid: req 0 owns, deasserts req_valid with req 1 pending. Expect req 1 granted that same cycle and owner_id=0 next cycle.
- Reset mid-burst with RD_LATENCY=2: assert reset for 1 cycle while 2 reads are in flight. Expect all outputs 0 the next cycle and no rsp_valid pulses for the dropped reads.

Source files
------------

// File: rtl/sobel_rd_port_arbiter.sv
// sobel_rd_port_arbiter
// Shares one single-port read BRAM between NUM_REQ Sobel patch fetchers.
// Arbitration is round-robin. A requester can hold a lock so that its 3x3 patch
// reads issue back-to-back. Read data returns to the requester that issued it.
//
// Ports:
//   clka, reset                 clock and synchronous active-high reset
//   req_valid/req_addr/req_lock per-requester read request, address slice, hold-ownership flag
//   req_ready                   combinational grant, one-hot or zero
//   rsp_valid/rsp_data          registered per-requester data strobe; data is the BRAM output
//   bram_ena/bram_addra         registered BRAM read port
//   bram_douta                  BRAM read data
//   owner_id                    current lock owner, 0 when unowned
//   stall_cnt                   saturating count of cycles with an unaccepted request
module sobel_rd_port_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_BURST  = 9
) (
    input  logic                        clka,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_lock,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        bram_ena,
    output logic [ADDR_W-1:0]           bram_addra,
    input  logic [DATA_W-1:0]           bram_douta,
    output logic [1:0]                  owner_id,
    output logic [15:0]                 stall_cnt
);

    localparam int unsigned ID_W    = 2;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_FREE,
        ST_OWNED
    } state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_owner;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [BURST_W-1:0]     r_burst_cnt;
    logic                   r_bram_ena;
    logic [ADDR_W-1:0]      r_bram_addra;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [15:0]            r_stall_cnt;
    logic [RD_LATENCY-1:0]  r_tag_vld;
    logic [ID_W-1:0]        r_tag_id [RD_LATENCY];

    logic [3:0]             w_valid_pad;
    logic [3:0]             w_lock_pad;
    logic                   w_owner_hold;
    logic [ID_W-1:0]        w_search_base;
    int unsigned            w_idx;
    logic                   w_found;
    logic [ID_W-1:0]        w_found_id;
    logic                   w_grant_vld;
    logic [ID_W-1:0]        w_grant_id;
    logic [ADDR_W-1:0]      w_grant_addr;
    logic [BURST_W-1:0]     w_burst_inc;
    logic                   w_stall;

    // Successor of a requester id, wrapping mod NUM_REQ.
    function automatic logic [ID_W-1:0] f_next_id(input logic [ID_W-1:0] id);
        if (32'(id) >= NUM_REQ - 1)
            return '0;
        else
            return id + ID_W'(1);
    endfunction

    // Grant selection: the owner keeps the port while valid; otherwise round-robin search.
    always_comb begin
        w_valid_pad   = 4'(req_valid);
        w_lock_pad    = 4'(req_lock);
        w_owner_hold  = (r_state == ST_OWNED) && w_valid_pad[r_owner];
        // An owner that drops valid releases this cycle; search starts just past it.
        w_search_base = (r_state == ST_OWNED) ? f_next_id(r_owner) : r_rr_ptr;
        w_idx         = 0;
        w_found       = 1'b0;
        w_found_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(w_search_base) + k;
            if (w_idx >= NUM_REQ)
                w_idx = w_idx - NUM_REQ;
            if (!w_found && w_valid_pad[w_idx[ID_W-1:0]]) begin
                w_found    = 1'b1;
                w_found_id = w_idx[ID_W-1:0];
            end
        end

        if (w_owner_hold) begin
            w_grant_vld = 1'b1;
            w_grant_id  = r_owner;
        end else begin
            w_grant_vld = w_found;
            w_grant_id  = w_found_id;
        end
        if (reset)
            w_grant_vld = 1'b0;

        w_grant_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(w_grant_id) == i)
                w_grant_addr = req_addr[i*ADDR_W +: ADDR_W];
        end

        req_ready   = w_grant_vld ? (NUM_REQ'(1) << w_grant_id) : '0;
        w_burst_inc = r_burst_cnt + BURST_W'(1);
        w_stall     = |(req_valid & ~req_ready);
    end

    // Ownership state, BRAM issue, return tag pipe and stall counter.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_state      <= ST_FREE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_bram_ena   <= 1'b0;
            r_bram_addra <= '0;
            r_rsp_valid  <= '0;
            r_stall_cnt  <= '0;
            r_tag_vld    <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++)
                r_tag_id[i] <= '0;
        end else begin
            r_bram_ena <= w_grant_vld;
            if (w_grant_vld)
                r_bram_addra <= w_grant_addr;

            if (w_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;

            // Tag pipe is aligned with the BRAM latency so responses leave in issue order.
            r_tag_vld[0] <= w_grant_vld;
            r_tag_id[0]  <= w_grant_id;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            r_rsp_valid <= r_tag_vld[RD_LATENCY-1]
                         ? (NUM_REQ'(1) << r_tag_id[RD_LATENCY-1]) : '0;

            if (w_owner_hold) begin
                r_burst_cnt <= w_burst_inc;
                // Release on lock drop or when the burst limit is reached.
                if (!w_lock_pad[r_owner] || (32'(w_burst_inc) >= MAX_BURST)) begin
                    r_state     <= ST_FREE;
                    r_rr_ptr    <= f_next_id(r_owner);
                    r_owner     <= '0;
                    r_burst_cnt <= '0;
                end
            end else if (w_found) begin
                if (w_lock_pad[w_found_id] && (MAX_BURST > 1)) begin
                    r_state     <= ST_OWNED;
                    r_owner     <= w_found_id;
                    r_burst_cnt <= BURST_W'(1);
                end else begin
                    r_state     <= ST_FREE;
                    r_owner     <= '0;
                    r_rr_ptr    <= f_next_id(w_found_id);
                    r_burst_cnt <= '0;
                end
            end else begin
                r_state     <= ST_FREE;
                r_owner     <= '0;
                r_rr_ptr    <= w_search_base;
                r_burst_cnt <= '0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = bram_douta;
    assign bram_ena   = r_bram_ena;
    assign bram_addra = r_bram_addra;
    assign owner_id   = r_owner;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_sobel_rd_port_arbiter.sv
// Directed bench for sobel_rd_port_arbiter: one instance at read latency 1 and one at
// latency 2 share the same request stimulus; each has its own BRAM model.
module tb_sobel_rd_port_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_lock;
    logic [NR*AW-1:0]  req_addr;

    logic [NR-1:0]     ready1, ready2, rspv1, rspv2;
    logic [DW-1:0]     rspd1, rspd2, douta1, douta2, pipe2;
    logic              ena1, ena2;
    logic [AW-1:0]     addra1, addra2;
    logic [1:0]        own1, own2;
    logic [15:0]       stall1, stall2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sobel_rd_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .MAX_BURST(9)) u_dut1 (
        .clka(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_lock(req_lock),
        .req_ready(ready1), .rsp_valid(rspv1), .rsp_data(rspd1), .bram_ena(ena1), .bram_addra(addra1),
        .bram_douta(douta1), .owner_id(own1), .stall_cnt(stall1));

    sobel_rd_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .MAX_BURST(9)) u_dut2 (
        .clka(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_lock(req_lock),
        .req_ready(ready2), .rsp_valid(rspv2), .rsp_data(rspd2), .bram_ena(ena2), .bram_addra(addra2),
        .bram_douta(douta2), .owner_id(own2), .stall_cnt(stall2));

    // Model BRAM contents.
    function automatic logic [7:0] mem_word(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // BRAM models with 1 and 2 cycles of read latency.
    always @(posedge clk) begin
        if (ena1)
            douta1 <= mem_word(addra1);
        if (ena2)
            pipe2 <= mem_word(addra2);
        douta2 <= pipe2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [15:0] a0, input logic [15:0] a1);
        req_valid = v;
        req_lock  = l;
        req_addr  = {a1, a0};
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 16'h0, 16'h0);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0]  exp_rdy;
        logic [1:0]  v;
        logic [1:0]  l;
        logic [15:0] a0;
        logic [15:0] exp_addr;
        int          idx;

        reset = 1'b1;
        drive(2'b00, 2'b00, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_ready", 32'(ready1), 32'h0);
        check_eq("rst_rspv", 32'(rspv1), 32'h0);
        check_eq("rst_ena", 32'(ena1), 32'h0);
        check_eq("rst_addra", 32'(addra1), 32'h0);
        check_eq("rst_owner", 32'(own1), 32'h0);
        check_eq("rst_stall", 32'(stall1), 32'h0);
        next_cyc();

        // Single requester, full latency path
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(2'b01, 2'b00, 16'h0102, 16'h0);
            else        drive(2'b00, 2'b00, 16'h0, 16'h0);
            @(negedge clk);
            case (k)
                0: check_eq("single_ready", 32'(ready1), 32'h1);
                1: begin
                    check_eq("single_ena", 32'(ena1), 32'h1);
                    check_eq("single_addra", 32'(addra1), 32'h0102);
                    check_eq("single_ready_idle", 32'(ready1), 32'h0);
                end
                2: begin
                    check_eq("single_rspv_l1", 32'(rspv1), 32'h1);
                    check_eq("single_rspd_l1", 32'(rspd1), 32'(mem_word(16'h0102)));
                    check_eq("single_ena_off", 32'(ena1), 32'h0);
                    check_eq("single_addra_hold", 32'(addra1), 32'h0102);
                end
                default: begin
                    check_eq("single_rspv_l2", 32'(rspv2), 32'h1);
                    check_eq("single_rspd_l2", 32'(rspd2), 32'(mem_word(16'h0102)));
                    check_eq("single_rspv_l1_done", 32'(rspv1), 32'h0);
                end
            endcase
            next_cyc();
        end

        // Contention without lock: alternating grants, stall count per cycle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(2'b11, 2'b00, 16'h1111, 16'h2222);
            else       drive(2'b00, 2'b00, 16'h0, 16'h0);
            @(negedge clk);
            exp_rdy = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            check_eq($sformatf("cont_ready_%0d", k), 32'(ready1), 32'(exp_rdy));
            check_eq($sformatf("cont_stall_%0d", k), 32'(stall1), (k < 4) ? 32'(k) : 32'd4);
            if (k >= 1 && k <= 4) begin
                exp_addr = ((k - 1) % 2 == 0) ? 16'h1111 : 16'h2222;
                check_eq($sformatf("cont_addra_%0d", k), 32'(addra1), 32'(exp_addr));
            end
            if (k >= 2) begin
                idx = k - 2;
                exp_addr = (idx % 2 == 0) ? 16'h1111 : 16'h2222;
                check_eq($sformatf("cont_rspv_%0d", k), 32'(rspv1), (idx % 2 == 0) ? 32'h1 : 32'h2);
                check_eq($sformatf("cont_rspd_%0d", k), 32'(rspd1), 32'(mem_word(exp_addr)));
            end
            next_cyc();
        end

        // Locked patch fetch: 9 beats to requester 0, lock dropped on the 9th
        do_reset();
        for (int k = 0; k < 12; k++) begin
            v[0] = (k < 9);
            v[1] = (k < 10);
            l    = {1'b0, (k < 8)};
            a0   = 16'(32'h1000 + k);
            drive(v, l, a0, 16'h2000);
            @(negedge clk);
            exp_rdy = (k < 9) ? 2'b01 : ((k == 9) ? 2'b10 : 2'b00);
            check_eq($sformatf("lock_ready_%0d", k), 32'(ready1), 32'(exp_rdy));
            if (k >= 2) begin
                idx = k - 2;
                if (idx < 9) begin
                    check_eq($sformatf("lock_rspv_%0d", k), 32'(rspv1), 32'h1);
                    check_eq($sformatf("lock_rspd_%0d", k), 32'(rspd1), 32'(mem_word(16'(32'h1000 + idx))));
                end else begin
                    check_eq($sformatf("lock_rspv_%0d", k), 32'(rspv1), 32'h2);
                    check_eq($sformatf("lock_rspd_%0d", k), 32'(rspd1), 32'(mem_word(16'h2000)));
                end
            end
            next_cyc();
        end

        // Forced release after MAX_BURST grants
        do_reset();
        for (int k = 0; k < 12; k++) begin
            v = {(k < 10) ? 1'b1 : 1'b0, 1'b1};
            drive(v, 2'b01, 16'h3000, 16'h4000);
            @(negedge clk);
            exp_rdy = (k == 9) ? 2'b10 : 2'b01;
            check_eq($sformatf("force_ready_%0d", k), 32'(ready1), 32'(exp_rdy));
            next_cyc();
        end

        // Owner 0 drops valid with requester 1 pending
        do_reset();
        drive(2'b01, 2'b01, 16'h0A00, 16'h0B00);
        @(negedge clk);
        check_eq("drop0_ready_c0", 32'(ready1), 32'h1);
        next_cyc();
        drive(2'b11, 2'b01, 16'h0A01, 16'h0B00);
        @(negedge clk);
        check_eq("drop0_ready_c1", 32'(ready1), 32'h1);
        next_cyc();
        drive(2'b10, 2'b00, 16'h0A02, 16'h0B00);
        @(negedge clk);
        check_eq("drop0_ready_c2", 32'(ready1), 32'h2);
        next_cyc();
        drive(2'b00, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        check_eq("drop0_owner", 32'(own1), 32'h0);
        check_eq("drop0_stall", 32'(stall1), 32'h1);
        check_eq("drop0_addra", 32'(addra1), 32'h0B00);
        next_cyc();

        // Owner 1 drops valid with requester 0 pending
        do_reset();
        drive(2'b10, 2'b10, 16'h0C00, 16'h0D00);
        @(negedge clk);
        check_eq("drop1_ready_c0", 32'(ready1), 32'h2);
        next_cyc();
        drive(2'b01, 2'b00, 16'h0C00, 16'h0D01);
        @(negedge clk);
        check_eq("drop1_owner_c1", 32'(own1), 32'h1);
        check_eq("drop1_ready_c1", 32'(ready1), 32'h1);
        next_cyc();
        drive(2'b00, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        check_eq("drop1_owner_c2", 32'(own1), 32'h0);
        check_eq("drop1_addra_c2", 32'(addra1), 32'h0C00);
        next_cyc();

        // Reset with two reads in flight on the latency-2 instance
        do_reset();
        drive(2'b11, 2'b00, 16'h5000, 16'h6000);
        @(negedge clk);
        check_eq("mid_ready_c0", 32'(ready2), 32'h1);
        next_cyc();
        @(negedge clk);
        check_eq("mid_ready_c1", 32'(ready2), 32'h2);
        next_cyc();
        drive(2'b00, 2'b00, 16'h0, 16'h0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_stall_pre", 32'(stall2), 32'h2);
        check_eq("mid_addra_pre", 32'(addra2), 32'h6000);
        next_cyc();
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_ena", 32'(ena2), 32'h0);
        check_eq("mid_addra", 32'(addra2), 32'h0);
        check_eq("mid_owner", 32'(own2), 32'h0);
        check_eq("mid_stall", 32'(stall2), 32'h0);
        check_eq("mid_ready", 32'(ready2), 32'h0);
        check_eq("mid_rspv_l2_c3", 32'(rspv2), 32'h0);
        check_eq("mid_rspv_l1_c3", 32'(rspv1), 32'h0);
        next_cyc();
        for (int k = 4; k < 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("mid_rspv_l2_c%0d", k), 32'(rspv2), 32'h0);
            check_eq($sformatf("mid_rspv_l1_c%0d", k), 32'(rspv1), 32'h0);
            next_cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
